// File: rtl/fc_sequencer.sv
// Handshake-driven sequencer for the FC1 -> tanh -> FC2 -> softmax back end.
// Drives per-stage resets/enables and weight addresses; all outputs are registered.
module fc_sequencer #(
  parameter int IN1     = 120,
  parameter int OUT1    = 84,
  parameter int ADDR_W  = 8,
  parameter int DRAIN   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              tanh_done,
  input  logic              smax_ack,
  output logic              fc1_reset,
  output logic              fc2_reset,
  output logic              tanh_reset,
  output logic              smax_enable,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] PARK = {ADDR_W{1'b1}};

  typedef enum logic [3:0] {
    IDLE, FC1_RUN, FC1_DRAIN, TANH, FC2_RUN, FC2_DRAIN, SMAX, FIN, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d, addr2_q, addr2_d;
  logic               fc1_reset_q, fc1_reset_d, fc2_reset_q, fc2_reset_d;
  logic               tanh_reset_q, tanh_reset_d, smax_enable_q, smax_enable_d;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic               go_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr1_q       <= '0;
      addr2_q       <= '0;
      fc1_reset_q   <= 1'b1;
      fc2_reset_q   <= 1'b1;
      tanh_reset_q  <= 1'b1;
      smax_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr1_q       <= addr1_d;
      addr2_q       <= addr2_d;
      fc1_reset_q   <= fc1_reset_d;
      fc2_reset_q   <= fc2_reset_d;
      tanh_reset_q  <= tanh_reset_d;
      smax_enable_q <= smax_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Outputs are computed for the state being entered, so they line up with state_q.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr1_d       = addr1_q;
    addr2_d       = addr2_q;
    fc1_reset_d   = fc1_reset_q;
    fc2_reset_d   = fc2_reset_q;
    tanh_reset_d  = tanh_reset_q;
    smax_enable_d = smax_enable_q;
    done_d        = 1'b0;
    error_d       = error_q;
    go_err        = 1'b0;

    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          state_d     = FC1_RUN;
          addr1_d     = '0;
          addr2_d     = '0;
          fc1_reset_d = 1'b0;
          error_d     = 1'b0;
        end
      end
      FC1_RUN: begin
        if (addr1_q == ADDR_W'(IN1 - 1)) begin
          state_d = FC1_DRAIN;
          addr1_d = PARK;
          cnt_d   = '0;
        end else begin
          addr1_d = addr1_q + 1'b1;
        end
      end
      FC1_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN - 1)) begin
          state_d      = TANH;
          cnt_d        = '0;
          tanh_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TANH: begin
        // The completion flag takes priority over a timeout in the same cycle.
        if (tanh_done) begin
          state_d     = FC2_RUN;
          addr2_d     = '0;
          fc2_reset_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          go_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FC2_RUN: begin
        if (addr2_q == ADDR_W'(OUT1 - 1)) begin
          state_d = FC2_DRAIN;
          addr2_d = PARK;
          cnt_d   = '0;
        end else begin
          addr2_d = addr2_q + 1'b1;
        end
      end
      FC2_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN - 1)) begin
          state_d       = SMAX;
          cnt_d         = '0;
          smax_enable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SMAX: begin
        if (smax_ack) begin
          state_d       = FIN;
          done_d        = 1'b1;
          fc1_reset_d   = 1'b1;
          fc2_reset_d   = 1'b1;
          tanh_reset_d  = 1'b1;
          smax_enable_d = 1'b0;
          addr1_d       = '0;
          addr2_d       = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          go_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_err) begin
      state_d       = ERROR;
      error_d       = 1'b1;
      fc1_reset_d   = 1'b1;
      fc2_reset_d   = 1'b1;
      tanh_reset_d  = 1'b1;
      smax_enable_d = 1'b0;
      addr1_d       = '0;
      addr2_d       = '0;
    end

    busy_d = (state_d != IDLE) && (state_d != ERROR);
  end

  assign fc1_reset   = fc1_reset_q;
  assign fc2_reset   = fc2_reset_q;
  assign tanh_reset  = tanh_reset_q;
  assign smax_enable = smax_enable_q;
  assign addr1       = addr1_q;
  assign addr2       = addr2_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: full runs, held start, timeout/recovery,
// async abort, tied-high flags with repeatable latency, flag-vs-timeout priority.
module tb_fc_sequencer;

  localparam int IN1     = 120;
  localparam int OUT1    = 84;
  localparam int ADDR_W  = 8;
  localparam int DRAIN   = 10;
  localparam int TIMEOUT = 1023;
  localparam int PARK    = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              tanh_done = 1'b0;
  logic              smax_ack = 1'b0;
  logic              fc1_reset, fc2_reset, tanh_reset, smax_enable;
  logic [ADDR_W-1:0] addr1, addr2;
  logic              busy, done, error;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_start = 0;
  int lat_a = 0;
  int lat_b = 0;

  fc_sequencer #(
    .IN1(IN1), .OUT1(OUT1), .ADDR_W(ADDR_W), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tanh_done(tanh_done),
    .smax_ack(smax_ack), .fc1_reset(fc1_reset), .fc2_reset(fc2_reset),
    .tanh_reset(tanh_reset), .smax_enable(smax_enable), .addr1(addr1),
    .addr2(addr2), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_vals(input string tag, input int exp_err);
    chk({tag, ".fc1_reset"}, fc1_reset, 1);
    chk({tag, ".fc2_reset"}, fc2_reset, 1);
    chk({tag, ".tanh_reset"}, tanh_reset, 1);
    chk({tag, ".smax_en"}, smax_enable, 0);
    chk({tag, ".addr1"}, addr1, 0);
    chk({tag, ".addr2"}, addr2, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".error"}, error, exp_err);
  endtask

  // Issue start, check the FC1 sweep and drain, return on the first TANH cycle.
  task automatic to_tanh(input bit hold);
    start = 1'b1;
    step();
    t_start = cyc;
    if (!hold) start = 1'b0;
    chk("run.busy", busy, 1);
    chk("run.err_clr", error, 0);
    chk("run.fc1_reset", fc1_reset, 0);
    for (int i = 0; i < IN1; i++) begin
      chk("addr1", addr1, i);
      step();
    end
    for (int i = 0; i < DRAIN; i++) begin
      chk("addr1_park", addr1, PARK);
      step();
    end
    chk("tanh.tanh_reset", tanh_reset, 0);
    chk("tanh.fc1_reset", fc1_reset, 0);
    chk("tanh.fc2_reset", fc2_reset, 1);
  endtask

  // From the first FC2_RUN cycle through the drain; returns on the first SMAX cycle.
  task automatic fc2_phase();
    chk("fc2.fc2_reset", fc2_reset, 0);
    chk("fc2.fc1_reset", fc1_reset, 0);
    chk("fc2.tanh_reset", tanh_reset, 0);
    for (int i = 0; i < OUT1; i++) begin
      chk("addr2", addr2, i);
      step();
    end
    for (int i = 0; i < DRAIN; i++) begin
      chk("addr2_park", addr2, PARK);
      step();
    end
    chk("smax.enable", smax_enable, 1);
    chk("smax.fc2_reset", fc2_reset, 0);
  endtask

  task automatic run(input int t_tanh, input int t_smax, input bit hold,
                     input bit tie, output int lat);
    int exp_lat;
    tanh_done = tie;
    smax_ack  = tie;
    to_tanh(hold);
    for (int k = 0; k < t_tanh; k++) step();
    tanh_done = 1'b1;
    step();
    tanh_done = tie;
    fc2_phase();
    for (int k = 0; k < t_smax; k++) step();
    smax_ack = 1'b1;
    step();
    smax_ack = tie;
    lat = cyc - t_start;
    exp_lat = IN1 + DRAIN + (t_tanh + 1) + OUT1 + DRAIN + (t_smax + 1);
    chk("fin.done", done, 1);
    chk("fin.busy", busy, 1);
    chk("fin.error", error, 0);
    chk("fin.fc1_reset", fc1_reset, 1);
    chk("fin.fc2_reset", fc2_reset, 1);
    chk("fin.tanh_reset", tanh_reset, 1);
    chk("fin.smax_en", smax_enable, 0);
    chk("fin.addr1", addr1, 0);
    chk("fin.addr2", addr2, 0);
    chk("latency", lat, exp_lat);
    step();
    chk_idle_vals("post_fin", 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle_vals("reset", 0);
    reset = 1'b0;
    step();
    chk_idle_vals("idle", 0);

    // Nominal run: tanh after 504 TANH cycles, softmax ack after 20
    run(504, 20, 1'b0, 1'b0, lat_a);
    repeat (3) begin
      step();
      chk("idle.no_done", done, 0);
    end

    // start held for the entire run: no restart while busy, new run only from IDLE
    run(3, 2, 1'b1, 1'b0, lat_a);
    step();
    chk("hold.restart_busy", busy, 1);
    chk("hold.restart_addr1", addr1, 0);
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk_idle_vals("hold.abort", 0);

    // tanh_done never arrives: timeout into ERROR
    to_tanh(1'b0);
    for (int k = 0; k < TIMEOUT - 1; k++) step();
    chk("to.pre_err", error, 0);
    chk("to.pre_busy", busy, 1);
    step();
    chk_idle_vals("to.err", 1);
    repeat (3) step();
    chk("to.sticky", error, 1);
    // Recovery via start, then async reset mid FC2_RUN at addr2=40
    to_tanh(1'b0);
    tanh_done = 1'b1;
    step();
    tanh_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("abort.addr2", addr2, i);
      step();
    end
    chk("abort.addr2_40", addr2, 40);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.addr2_rst", addr2, 0);
    chk("abort.fc2_reset", fc2_reset, 1);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    step();
    reset = 1'b0;
    repeat (4) begin
      step();
      chk("abort.no_done", done, 0);
      chk("abort.idle_busy", busy, 0);
    end

    // Flags tied high: one cycle each in TANH and SMAX, identical latency twice
    run(0, 0, 1'b0, 1'b1, lat_a);
    run(0, 0, 1'b0, 1'b1, lat_b);
    chk("tied.latency_a", lat_a, 226);
    chk("tied.repeatable", lat_b, lat_a);
    tanh_done = 1'b0;
    smax_ack  = 1'b0;
    step();

    // smax_ack on the same cycle the SMAX timeout would fire: flag wins
    run(7, TIMEOUT - 1, 1'b0, 1'b0, lat_a);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
